spi_slave_rx_tx: RTL
====================

# spi_slave_rx_tx

Mode-0 SPI responder (CPOL=0, CPHA=0, MSB first) that sits on the far end of the SPI link from the master, whose SCLK comes from the clock divider. It oversamples the external `sclk`, `cs_n` and `mosi` pins on the local system clock. It deserialises received words into `rx_data` and serialises words from a one-deep transmit holding register onto `miso`. Full-duplex: one word in, one word out per `DATA_W` SCLK periods.

## Interface
- `DATA_W`, 8: word length in bits.
- `SYNC_STAGES`, 2: flip-flop depth of each pin synchroniser; minimum 2.
- `clk`  in  1  system clock; rising edge only.
- `rst`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from master; asynchronous to `clk`.
- `cs_n`  in  1  chip select, active low; asynchronous.
- `mosi`  in  1  master-out data; asynchronous.
- `miso`  out  1  slave-out data.
- `miso_oe`  out  1  output enable for the `miso` pad; high only while selected.
- `tx_data`  in  DATA_W  word to transmit.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  holding register empty.
- `rx_data`  out  DATA_W  last complete received word.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `tx_underrun`  out  1  one-cycle strobe: a word started with an empty holding register.
- `busy`  out  1  high while `cs_n` is (synchronised) low.

## Operation
- Pins pass through `SYNC_STAGES` FFs. Edge detect on the synchronised `sclk`/`cs_n` produces the strobes `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`. `mosi` uses the same depth, so it is aligned with `sclk_rise`.
- FSM states:
  - IDLE: `cs_n` high.
  - LOAD: one cycle; shift register loaded.
  - SHIFT: bits transferring.
- Transitions:
  - IDLE→LOAD on `cs_fall`.
  - LOAD→SHIFT unconditionally.
  - SHIFT→LOAD after the `sclk_fall` that follows the DATA_W-th `sclk_rise`.
  - Any state→IDLE on `cs_rise`.
- LOAD:
  - If the holding register is full: move it into `tx_shift` and set `tx_ready`=1.
  - If empty: load all-zeros and pulse `tx_underrun`.
  - `miso` = `tx_shift` MSB.
  - Bit counter = 0.
- SHIFT:
  - On `sclk_rise`: `rx_shift` ← {`rx_shift`[DATA_W-2:0], `mosi`}; counter+1.
  - When the counter reaches DATA_W: `rx_data` ← the new `rx_shift` and pulse `rx_valid` on the same edge.
  - On `sclk_fall` with counter<DATA_W: shift `tx_shift` left and drive the next MSB onto `miso`.
- Holding register: `tx_data` is captured when `tx_valid && tx_ready`, and `tx_ready` then drops.
  - If the capture and a LOAD fall in the same cycle, the LOAD sees the register as empty: it underruns, and the new word stays held for the next word.
- `cs_rise` mid-word: discard the partial `rx_shift` and `tx_shift`, no `rx_valid`, counter=0. The holding register is kept.
- `rx_valid` strobes with no consumer handshake. A word not taken before the next strobe is overwritten.
- While in IDLE: `miso`=0 and `miso_oe`=0. `sclk` activity is ignored.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `busy`=0. FSM=IDLE, counters and shift registers = 0.
- Pin edge → internal strobe: SYNC_STAGES+1 `clk` cycles (+0/+1 for sampling phase).
- `miso` changes at most SYNC_STAGES+2 cycles after a pad SCLK falling edge. The `cs_n`-fall → first bit path has the same latency.
- Required link timing: each SCLK half-period ≥ SYNC_STAGES+3 `clk` periods. At 100 MHz with SYNC_STAGES=2, this allows SCLK ≤ 10 MHz, so 6.25 MHz is supported.
- The `cs_n` setup time before the first SCLK rise is ≥ the same bound.
- `rx_valid` rises SYNC_STAGES+1 cycles after the DATA_W-th pad SCLK rise (+0/+1 for sampling phase).
- `tx_ready` re-asserts in the LOAD cycle.

## Structure
- Shared package `spi_pkg`:
  - `SPI_DATA_W` default.
  - FSM state enum (IDLE, LOAD, SHIFT).
  - `SPI_MIN_HALF_PERIOD` constant.
- Sub-module `spi_pin_sync`: an N-stage synchroniser plus registered rise/fall detect, with async active-low reset. Instantiated for `sclk` and `cs_n`. `mosi` uses a plain synchroniser of equal depth.

## Test plan
- Preload `tx_data`=0xA5. Master sends 0x3C at SCLK = clk/16 → `rx_data`=0x3C with one `rx_valid` pulse; master reads 0xA5; `tx_ready` returns to 1.
- Hold `cs_n` low for 3 words; master sends 0x01,0x80,0xFF while the slave queues 0x11,0x22,0x33 → three `rx_valid` pulses with the matching data; master reads 0x11,0x22,0x33.
- Transfer with no `tx_valid` → `tx_underrun` pulses once; master reads 0x00; the received word is still correct.
- Raise `cs_n` after 5 bits of 0xF0, then run a full transfer of 0x5A → no `rx_valid` for the partial word; the second word gives `rx_data`=0x5A; the queued TX word is sent intact.
- Assert `rst` low mid-word (bit 4) → all outputs reach reset values asynchronously; after release, a full 0xC3 transfer completes correctly.
- SCLK at the minimum half-period (5 `clk`) with `sclk`/`mosi` phase randomised against `clk` → 100 random words are received and transmitted with zero errors.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pkg : shared constants and FSM encoding for the SPI responder.
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATA_W          = 8;
  localparam int SPI_SYNC_STAGES     = 2;
  // Shortest SCLK half-period (in clk cycles) the oversampling front end tolerates.
  localparam int SPI_MIN_HALF_PERIOD = SPI_SYNC_STAGES + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_pin_sync : N-stage synchroniser with rise/fall detect on the synced level.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], pin};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign rise = r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_slave_rx_tx : oversampled mode-0 SPI responder, full duplex, MSB first.
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_W);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (sclk),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall)
  );

  // Chip select idles high, so its synchroniser resets high to avoid a false cs_fall.
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (cs_n),
    .rise (w_cs_rise),
    .fall (w_cs_fall)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mosi_sync <= '0;
    else      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  spi_state_t          r_state,    w_state;
  logic [c_CNT_W-1:0]  r_cnt,      w_cnt;
  logic [DATA_W-1:0]   r_rx_shift, w_rx_shift;
  logic [DATA_W-1:0]   r_tx_shift, w_tx_shift;
  logic [DATA_W-1:0]   r_rx_data,  w_rx_data;
  logic [DATA_W-1:0]   r_hold,     w_hold;
  logic                r_hold_full, w_hold_full;
  logic                r_rx_valid, w_rx_valid;
  logic                r_underrun, w_underrun;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_rx_shift  = r_rx_shift;
    w_tx_shift  = r_tx_shift;
    w_rx_data   = r_rx_data;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_rx_valid  = 1'b0;
    w_underrun  = 1'b0;

    if (tx_valid && !r_hold_full) begin
      w_hold      = tx_data;
      w_hold_full = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_cs_fall) w_state = LOAD;
      end
      LOAD: begin
        w_cnt   = '0;
        w_state = SHIFT;
        // Uses the registered full flag: a word captured this very cycle waits for the next LOAD.
        if (r_hold_full) begin
          w_tx_shift  = r_hold;
          w_hold_full = 1'b0;
        end else begin
          w_tx_shift = '0;
          w_underrun = 1'b1;
        end
      end
      SHIFT: begin
        if (w_sclk_rise && (r_cnt != c_CNT_FULL)) begin
          w_rx_shift = {r_rx_shift[DATA_W-2:0], w_mosi};
          w_cnt      = r_cnt + 1'b1;
          if (w_cnt == c_CNT_FULL) begin
            w_rx_data  = w_rx_shift;
            w_rx_valid = 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_cnt == c_CNT_FULL) w_state = LOAD;
          else                     w_tx_shift = {r_tx_shift[DATA_W-2:0], 1'b0};
        end
      end
      default: w_state = IDLE;
    endcase

    // Deselect abandons any partial word but leaves the holding register alone.
    if (w_cs_rise) begin
      w_state    = IDLE;
      w_cnt      = '0;
      w_rx_shift = '0;
      w_tx_shift = '0;
      w_rx_valid = 1'b0;
      w_underrun = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_rx_data   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_rx_shift  <= w_rx_shift;
      r_tx_shift  <= w_tx_shift;
      r_rx_data   <= w_rx_data;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_rx_valid  <= w_rx_valid;
      r_underrun  <= w_underrun;
    end
  end

  // The shift register is cleared whenever deselected, so miso rests low in IDLE.
  assign miso        = r_tx_shift[DATA_W-1];
  assign miso_oe     = (r_state != IDLE);
  assign busy        = (r_state != IDLE);
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;

endmodule
`default_nettype wire
